sha256_pad: RTL
===============

# sha256_pad

Message padder that sits directly upstream of the SHA-256 compression core. It accepts an arbitrary-length message one byte at a time and emits FIPS 180-4 padded 512-bit blocks, one per handshake, in the big-endian packing the core consumes. It also generates the core's `new_hash` flag so that each message restarts the chaining state. A `last_block` flag tells downstream logic (PBKDF2/HMAC sequencing) which digest is final.

## Interface
- `LEN_W`, default 61: width of the message byte counter. The length field is `{count, 3'b000}`, zero-extended to 64 bits. The counter wraps modulo 2^LEN_W.
- `clk_i` input, 1 bit: single clock; all logic is on the rising edge.
- `rst_ni` input, 1 bit: synchronous reset, active low.
- `in_valid` input, 1 bit: `in_byte` is valid.
- `in_byte` input, 8 bits: next message byte, in message order.
- `in_last` input, 1 bit: this byte is the final byte of the message. Messages are at least 1 byte long.
- `in_ready` output, 1 bit: byte accepted on an edge where `in_valid && in_ready`.
- `out_valid` output, 1 bit: `out` holds a complete block.
- `out` output, 512 bits: padded block. Message byte 0 of the block is at `out[511:504]`, byte 63 at `out[7:0]`.
- `new_hash` output, 1 bit: this is the first block of a message.
- `last_block` output, 1 bit: this is the final block of a message.
- `out_ready` input, 1 bit: block consumed on an edge where `out_valid && out_ready`.

## Operation
- **Registers:**
  - 512-bit block buffer
  - 6-bit byte index `idx` (position within the block)
  - LEN_W-bit byte count `len`
  - `first` flag (next emitted block starts a message)
  - `pend` flag (extra length block owed)
- **States:**
  - FILL: `in_ready=1`.
  - SEND: `out_valid=1`, `in_ready=0`.
  - SEND_X: `out_valid=1`, `in_ready=0`; presents the extra padding block.
- **FILL, byte accepted with `in_last=0`:** write the byte at `idx`, increment `idx` and `len`. If `idx` was 63, go to SEND with `new_hash=first`, `last_block=0`.
- **FILL, byte accepted with `in_last=1`:** let n = `idx`+1 (bytes in this block) and L = `len`+1 (total message bytes). The block is completed in the same cycle:
  - n ≤ 55: bytes n..55 are 0x80 followed by zeros; bytes 56..63 = L·8 big-endian. Go to SEND with `last_block=1`, `pend=0`.
  - 56 ≤ n ≤ 63: byte n = 0x80, remaining bytes 0. Go to SEND with `last_block=0`, `pend=1`, extra block = zeros plus length.
  - n = 64: no padding in this block. Go to SEND with `last_block=0`, `pend=1`, extra block = 0x80 at byte 0, zeros, then length.
- **SEND handshake:**
  - If `pend`: load the extra block, go to SEND_X with `new_hash=0`, `last_block=1`.
  - Else: clear the buffer and `idx`, set `first = last_block`, and return to FILL. `len` is cleared only after a final block.
- **SEND_X handshake:** clear the buffer, `idx` and `len`, set `first=1`, `pend=0`, and return to FILL.
- `new_hash=1` only on the first block of each message. A one-block message has `new_hash=1` and `last_block=1`.
- **Reset mid-operation:** the partial message is discarded with no output, and the next message begins fresh with `new_hash=1`.

## Timing
- **Reset values while `rst_ni=0`:**
  - `in_ready=0`, `out_valid=0`, `out=0`, `new_hash=0`, `last_block=0`
  - state FILL, `idx=0`, `len=0`, `first=1`, `pend=0`
- `in_ready=1` in the first cycle after `rst_ni` rises.
- **Output latency:** the byte that completes a block is accepted at edge N; `out_valid=1` from edge N onward. The extra block is presented the edge after the SEND handshake.
- **Stalls:** `out`, `new_hash` and `last_block` are held stable while `out_valid && !out_ready`. No byte is accepted while `out_valid=1`.
- **Throughput:** a full block takes 64 accept cycles plus at least 1 output cycle. FILL resumes the cycle after the final handshake.
- `in_valid` with `in_ready=0` is ignored: no state change, and the byte is not consumed.
- `len` wrap at 2^LEN_W is silent.

## Test plan
- **"abc":** bytes 0x61, 0x62, 0x63 (last) → one block, `out = 0x61626380` followed by zeros, low 64 bits = 0x18, `new_hash=1`, `last_block=1`. Feeding it to the core gives `ba7816bf…f20015ad`.
- **55 bytes of 0x00, last on byte 54:** → one block, byte 55 = 0x80, length = 0x1B8, flags 1/1.
- **56 bytes of 0x00:**
  - Block A: byte 56 = 0x80, no length, `new_hash=1`, `last_block=0`.
  - Block B: all zeros except length 0x1C0, `new_hash=0`, `last_block=1`.
- **64 bytes of 0xFF:**
  - Block A: all 0xFF, flags 1/0.
  - Block B: byte 0 = 0x80, length 0x200, flags 0/1.
- **Backpressure:** hold `out_ready=0` for 10 cycles during 130-byte message block 1 → `out` stable and `in_ready=0` throughout. Three blocks follow with flags 1/0, 0/0, 0/1 and length 0x410.
- **Reset mid-message:** pulse `rst_ni=0` for one cycle after 20 bytes → `out_valid` stays 0, and a subsequent "abc" reproduces the first test exactly.

Source files
------------

// File: rtl/sha256_pad_if.sv
// Byte-in / block-out handshake bundle between the message source, the SHA-256
// padder and the compression core.
`timescale 1ns/1ps
interface sha256_pad_if;
    logic         in_valid;
    logic [7:0]   in_byte;
    logic         in_last;
    logic         in_ready;
    logic         out_valid;
    logic [511:0] out;
    logic         new_hash;
    logic         last_block;
    logic         out_ready;

    modport slave (
        input  in_valid, in_byte, in_last, out_ready,
        output in_ready, out_valid, out, new_hash, last_block
    );

    modport master (
        output in_valid, in_byte, in_last, out_ready,
        input  in_ready, out_valid, out, new_hash, last_block
    );
endinterface

// File: rtl/sha256_pad.sv
// FIPS 180-4 message padder: packs bytes big-endian into 512-bit blocks, appends
// 0x80 / zeros / 64-bit bit length, and flags the first and final block of each message.
`timescale 1ns/1ps
module sha256_pad #(
    parameter int LEN_W = 61
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    sha256_pad_if.slave  bus
);

    localparam logic [1:0] S_FILL   = 2'd0;
    localparam logic [1:0] S_SEND   = 2'd1;
    localparam logic [1:0] S_SEND_X = 2'd2;

    logic [1:0]       r_state;
    logic [511:0]     r_buf;
    logic [5:0]       r_idx;
    logic [LEN_W-1:0] r_len;
    logic             r_first;
    logic             r_pend;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_new_hash;
    logic             r_last_block;

    logic             w_acc;
    logic             w_hs;
    logic [6:0]       w_n;
    logic [LEN_W-1:0] w_len_inc;
    logic [511:0]     w_pad80;
    logic [511:0]     w_len_part;
    logic [511:0]     w_fill_blk;
    logic [511:0]     w_x_blk;

    // Byte pos of the block occupies bits [511-8*pos -: 8].
    function automatic logic [511:0] put_byte(input logic [5:0] pos, input logic [7:0] b);
        put_byte = {504'd0, b} << {~pos, 3'b000};
    endfunction

    function automatic logic [63:0] len_bits(input logic [LEN_W-1:0] l);
        len_bits = 64'({l, 3'b000});
    endfunction

    assign w_acc      = bus.in_valid & r_in_ready;
    assign w_hs       = r_out_valid & bus.out_ready;
    assign w_n        = {1'b0, r_idx} + 7'd1;
    assign w_len_inc  = r_len + LEN_W'(1'b1);

    // Bytes beyond idx are always zero in r_buf, so padding can be OR-ed in.
    assign w_pad80    = (bus.in_last && (w_n <= 7'd63)) ? put_byte(w_n[5:0], 8'h80) : 512'd0;
    assign w_len_part = (bus.in_last && (w_n <= 7'd55)) ? {448'd0, len_bits(w_len_inc)} : 512'd0;
    assign w_fill_blk = r_buf | put_byte(r_idx, bus.in_byte) | w_pad80 | w_len_part;

    // idx wraps to 0 only when the final byte filled the whole block, so the 0x80 moves here.
    assign w_x_blk    = {((r_idx == 6'd0) ? 8'h80 : 8'h00), 440'd0, len_bits(r_len)};

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out        = r_buf;
    assign bus.new_hash   = r_new_hash;
    assign bus.last_block = r_last_block;

    // Fill / send / extra-block sequencing with registered handshake outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state      <= S_FILL;
            r_buf        <= 512'd0;
            r_idx        <= 6'd0;
            r_len        <= '0;
            r_first      <= 1'b1;
            r_pend       <= 1'b0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_new_hash   <= 1'b0;
            r_last_block <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    r_in_ready <= 1'b1;
                    if (w_acc) begin
                        r_buf <= w_fill_blk;
                        r_idx <= r_idx + 6'd1;
                        r_len <= w_len_inc;
                        if (bus.in_last) begin
                            r_state      <= S_SEND;
                            r_in_ready   <= 1'b0;
                            r_out_valid  <= 1'b1;
                            r_new_hash   <= r_first;
                            r_last_block <= (w_n <= 7'd55);
                            r_pend       <= (w_n > 7'd55);
                        end else if (r_idx == 6'd63) begin
                            r_state      <= S_SEND;
                            r_in_ready   <= 1'b0;
                            r_out_valid  <= 1'b1;
                            r_new_hash   <= r_first;
                            r_last_block <= 1'b0;
                        end
                    end
                end
                S_SEND: begin
                    if (w_hs) begin
                        if (r_pend) begin
                            r_buf        <= w_x_blk;
                            r_state      <= S_SEND_X;
                            r_new_hash   <= 1'b0;
                            r_last_block <= 1'b1;
                        end else begin
                            r_buf        <= 512'd0;
                            r_idx        <= 6'd0;
                            r_first      <= r_last_block;
                            r_state      <= S_FILL;
                            r_in_ready   <= 1'b1;
                            r_out_valid  <= 1'b0;
                            r_new_hash   <= 1'b0;
                            r_last_block <= 1'b0;
                            if (r_last_block) begin
                                r_len <= '0;
                            end
                        end
                    end
                end
                S_SEND_X: begin
                    if (w_hs) begin
                        r_buf        <= 512'd0;
                        r_idx        <= 6'd0;
                        r_len        <= '0;
                        r_first      <= 1'b1;
                        r_pend       <= 1'b0;
                        r_state      <= S_FILL;
                        r_in_ready   <= 1'b1;
                        r_out_valid  <= 1'b0;
                        r_new_hash   <= 1'b0;
                        r_last_block <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_FILL;
                    r_buf       <= 512'd0;
                    r_idx       <= 6'd0;
                    r_len       <= '0;
                    r_first     <= 1'b1;
                    r_pend      <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
